// File: rtl/alt_cal_scheduler.sv
// Round-robin scheduler sharing one alt_cal engine across NUM_GROUPS channel groups.
// Optional macro ALT_CAL_SCHED_RETRY_EN: a grant's first failure re-runs calibration once.
//
// state  | meaning
// IDLE   | no grant; arbitrate pending requests
// RST    | 1 cycle, cal_reset asserted to alt_cal
// SETTLE | SETTLE_CYCLES quiet cycles after reset release
// START  | 1 cycle, cal_start asserted
// RUN    | watch busy/error, bounded by TIMEOUT_CYCLES
// DONE   | 1 cycle, cal_done pulse, group fail flag cleared
// FAIL   | 1 cycle, cal_done pulse, group fail flag set
module alt_cal_scheduler #(
  parameter int NUM_GROUPS     = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_GROUPS-1:0] cal_req,
  input  logic                  transceiver_init,
  output logic [NUM_GROUPS-1:0] cal_grant,
  output logic [NUM_GROUPS-1:0] cal_done,
  output logic [NUM_GROUPS-1:0] cal_fail,
  output logic                  cal_reset,
  output logic                  cal_start,
  input  logic                  cal_busy,
  input  logic                  cal_error,
  output logic                  sched_idle
);

  localparam int IDX_W   = $clog2(NUM_GROUPS);
  localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETTLE, S_START, S_RUN, S_DONE, S_FAIL
  } state_t;

  state_t                  state, state_nxt, fail_tgt;
  logic [IDX_W-1:0]        rr_ptr, grp, pick, idx;
  logic [IDX_W:0]          idx_sum;
  logic                    pick_vld;
  logic [NUM_GROUPS-1:0]   grant_q, fail_q;
  logic [TMR_W-1:0]        tmr;
  logic                    busy_low_q;

`ifdef ALT_CAL_SCHED_RETRY_EN
  logic retry_q;

  assign fail_tgt = retry_q ? S_FAIL : S_RST;

  always_ff @(posedge clock) begin
    if (reset)
      retry_q <= 1'b0;
    else if (state == S_IDLE)
      retry_q <= 1'b0;
    else if (state == S_RUN && state_nxt == S_RST)
      retry_q <= 1'b1;
  end
`else
  assign fail_tgt = S_FAIL;
`endif

  // First requester at or after the pointer, wrapping modulo NUM_GROUPS.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx_sum  = '0;
    idx      = '0;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      idx_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (idx_sum >= (IDX_W+1)'(NUM_GROUPS))
        idx_sum = idx_sum - (IDX_W+1)'(NUM_GROUPS);
      idx = idx_sum[IDX_W-1:0];
      if (!pick_vld && cal_req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pick_vld && !transceiver_init) state_nxt = S_RST;
      S_RST:    state_nxt = transceiver_init ? S_IDLE : S_SETTLE;
      S_SETTLE: begin
        if (transceiver_init)  state_nxt = S_IDLE;
        else if (tmr == '0)    state_nxt = S_START;
      end
      S_START:  state_nxt = transceiver_init ? S_IDLE : S_RUN;
      S_RUN: begin
        if (transceiver_init)             state_nxt = S_IDLE;
        else if (cal_error)               state_nxt = fail_tgt;
        else if (!cal_busy && busy_low_q) state_nxt = S_DONE;
        else if (tmr == '0)               state_nxt = fail_tgt;
      end
      S_DONE, S_FAIL: state_nxt = S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Grant, pointer, sticky fail flags and the shared settle/timeout down-counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      grp        <= '0;
      grant_q    <= '0;
      fail_q     <= '0;
      tmr        <= '0;
      busy_low_q <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nxt == S_RST) begin
        grp     <= pick;
        grant_q <= NUM_GROUPS'(1) << pick;
      end else if (state == S_DONE || state == S_FAIL) begin
        grant_q <= '0;
        rr_ptr  <= (grp == IDX_W'(NUM_GROUPS-1)) ? '0 : grp + 1'b1;
      end else if (state_nxt == S_IDLE) begin
        grant_q <= '0;
      end

      if (state_nxt == S_DONE)
        fail_q[grp] <= 1'b0;
      else if (state_nxt == S_FAIL)
        fail_q[grp] <= 1'b1;

      if (state != S_SETTLE && state_nxt == S_SETTLE)
        tmr <= TMR_W'(SETTLE_CYCLES - 1);
      else if (state == S_START && state_nxt == S_RUN)
        tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
      else if ((state == S_SETTLE || state == S_RUN) && tmr != '0)
        tmr <= tmr - 1'b1;

      busy_low_q <= (state == S_RUN) ? ~cal_busy : 1'b0;
    end
  end

  always_comb begin
    cal_reset  = (state == S_RST);
    cal_start  = (state == S_START);
    sched_idle = (state == S_IDLE);
    cal_done   = (state == S_DONE || state == S_FAIL) ? grant_q : '0;
  end

  assign cal_grant = grant_q;
  assign cal_fail  = fail_q;

endmodule
